// File: rtl/bcd_event_counter.sv
// bcd_event_counter
//   Eight-digit packed-BCD up/down event counter. An asynchronous count pulse
//   is synchronized and edge-detected, then steps a live BCD count. A
//   free-running prescaler offers a publish opportunity every UPDATE_PERIOD
//   cycles. At that point the live count is copied to cnt_out, with a
//   one-cycle trigger, but only if the count changed or a publish is forced.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   cnt_pulse  asynchronous count event (rising edge counts once)
//   up_down    1 = increment, 0 = decrement
//   enable     0 discards count events
//   clear      zeroes live count and overflow, forces the next publish
//   cnt_out    published snapshot, digit 0 in [3:0]
//   trigger    one-cycle pulse when a new cnt_out first appears
//   overflow   sticky wrap flag

// One BCD digit of the ripple chain. cin is "this digit steps". cout is
// the carry (up) or borrow (down) into the next digit.
module bcd_digit (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= 4'd9) begin
          q    = 4'd0;
          cout = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          q    = 4'd9;
          cout = 1'b1;
        end else if (d > 4'd9) begin
          q = 4'd9;
        end else begin
          q = d - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_event_counter #(
  parameter int UPDATE_PERIOD = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_pulse,
  input  logic        up_down,
  input  logic        enable,
  input  logic        clear,
  output logic [31:0] cnt_out,
  output logic        trigger,
  output logic        overflow
);
  localparam int NUM_DIGITS = 8;
  localparam int PW         = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;

  // sync_pipe[0]=s1, [1]=s2, [2]=s3
  logic [2:0]                  sync_pipe;
  logic [NUM_DIGITS-1:0][3:0]  live;
  logic [NUM_DIGITS-1:0][3:0]  live_nxt;
  logic [NUM_DIGITS:0]         carry;
  logic [PW-1:0]               presc;
  logic                        force_pub;
  logic                        ev;
  logic                        tick;
  logic                        wrap;

  assign ev       = sync_pipe[1] & ~sync_pipe[2];
  assign tick     = (presc == PW'(UPDATE_PERIOD - 1));
  assign carry[0] = 1'b1;
  assign wrap     = carry[NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .d    (live[g]),
      .up   (up_down),
      .cin  (carry[g]),
      .q    (live_nxt[g]),
      .cout (carry[g+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_pipe <= '0;
      live      <= '0;
      cnt_out   <= '0;
      trigger   <= 1'b0;
      overflow  <= 1'b0;
      presc     <= '0;
      force_pub <= 1'b1;
    end else begin
      sync_pipe <= {sync_pipe[1:0], cnt_pulse};
      presc     <= tick ? '0 : presc + PW'(1);
      trigger   <= 1'b0;

      // Publish looks at the pre-update live value, so an event landing on
      // the tick cycle shows up at the following tick.
      if (tick && ((live != cnt_out) || force_pub)) begin
        cnt_out   <= live;
        trigger   <= 1'b1;
        force_pub <= 1'b0;
      end

      // Clear wins over a coincident event and re-arms the forced publish.
      if (clear) begin
        live      <= '0;
        overflow  <= 1'b0;
        force_pub <= 1'b1;
      end else if (ev && enable) begin
        live <= live_nxt;
        if (wrap) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bcd_event_counter.sv
module tb_bcd_event_counter;
  localparam int P = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cnt_pulse = 1'b0;
  logic        up_down = 1'b1;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic [31:0] cnt_out;
  logic        trigger;
  logic        overflow;

  always #5 clk = ~clk;

  bcd_event_counter #(.UPDATE_PERIOD(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_pulse (cnt_pulse),
    .up_down   (up_down),
    .enable    (enable),
    .clear     (clear),
    .cnt_out   (cnt_out),
    .trigger   (trigger),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit valid_bcd(input logic [31:0] v);
    for (int i = 0; i < 8; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: decimal integer count, cycle-accurate publish schedule.
  int live_m = 0, pub_m = 0, pc_m = 0;
  bit force_m = 1'b1, ovf_m = 1'b0;
  bit [2:0] hist = '0;   // cnt_pulse samples, [0] most recent

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      live_m = 0; pub_m = 0; pc_m = 0; force_m = 1'b1; ovf_m = 1'b0; hist = '0;
      sb_q.delete();
    end else begin
      bit ev, pub, novf, nforce;
      int nlive;
      exp_t e;
      ev     = hist[1] && !hist[2];
      nlive  = live_m;
      novf   = ovf_m;
      nforce = force_m;
      pub    = (pc_m == P-1) && ((live_m != pub_m) || force_m);
      if (pub) nforce = 1'b0;
      if (clear) begin
        nlive = 0; novf = 1'b0; nforce = 1'b1;
      end else if (ev && enable) begin
        if (up_down) begin
          nlive = live_m + 1;
          if (nlive == 100000000) begin nlive = 0; novf = 1'b1; end
        end else if (live_m == 0) begin
          nlive = 99999999; novf = 1'b1;
        end else begin
          nlive = live_m - 1;
        end
      end
      if (pub) begin
        e.cnt = to_bcd(live_m);
        e.ovf = novf;
        sb_q.push_back(e);
        pub_m = live_m;
      end
      live_m  = nlive;
      ovf_m   = novf;
      force_m = nforce;
      pc_m    = (pc_m + 1) % P;
      hist    = {hist[1:0], cnt_pulse};
    end
  end

  // Monitor: every trigger must match a predicted publish, and vice versa.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset && trigger) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_trigger: cnt_out %h, no publish expected", cnt_out);
      end else begin
        e = sb_q.pop_front();
        chk("pub_cnt", cnt_out, e.cnt);
        chk("pub_ovf", {31'b0, overflow}, {31'b0, e.ovf});
        chk("pub_bcd_valid", {31'b0, valid_bcd(cnt_out)}, 32'd1);
      end
    end else if (reset && sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL missing_trigger: trigger %b, expected publish of %h", trigger, sb_q[0].cnt);
      sb_q.delete();
    end
  end

  task automatic pulse(input bit up);
    int hi, lo;
    hi = $urandom_range(2, 3);
    lo = $urandom_range(2, 3);
    @(negedge clk);
    up_down   = up;
    cnt_pulse = 1'b1;
    repeat (hi) @(negedge clk);
    cnt_pulse = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    idle(2*P + 4);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic first_trigger(input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 3*P && n == 0; i++) begin
      @(negedge clk);
      if (trigger) n = i;
    end
    chk(name, 32'(n), 32'(P));
  endtask

  task automatic wait_pc(input int v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2*P && !found; i++) begin
      @(negedge clk);
      if (pc_m == v) found = 1'b1;
    end
    if (!found) begin
      n_chk++;
      $display("FAIL wait_pc: prescaler %0d never seen, expected %0d", pc_m, v);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_cnt_out", cnt_out, 32'h0);
    chk("rst_trigger", {31'b0, trigger}, 32'h0);
    chk("rst_overflow", {31'b0, overflow}, 32'h0);
    idle(3);
    reset = 1'b1;
    first_trigger("first_trigger_cycle");
    idle(3*P);
    chk("idle_cnt", cnt_out, 32'h0);
    chk("idle_ovf", {31'b0, overflow}, 32'h0);

    // Up counting with carries
    repeat (9) pulse(1'b1);
    settle();
    chk("up_9", cnt_out, 32'h00000009);
    pulse(1'b1);
    settle();
    chk("up_10", cnt_out, 32'h00000010);
    repeat (1224) pulse(1'b1);
    settle();
    chk("up_1234", cnt_out, 32'h00001234);

    // Down through zero, sticky overflow, up wrap, clear
    clear_pulse();
    settle();
    chk("clear_cnt", cnt_out, 32'h0);
    pulse(1'b1);
    settle();
    chk("down_start", cnt_out, 32'h00000001);
    pulse(1'b0);
    pulse(1'b0);
    settle();
    chk("underflow_cnt", cnt_out, 32'h99999999);
    chk("underflow_ovf", {31'b0, overflow}, 32'h1);
    idle(3*P);
    chk("ovf_sticky", {31'b0, overflow}, 32'h1);
    pulse(1'b1);
    settle();
    chk("upwrap_cnt", cnt_out, 32'h0);
    chk("upwrap_ovf", {31'b0, overflow}, 32'h1);
    clear_pulse();
    chk("clear_ovf", {31'b0, overflow}, 32'h0);
    settle();

    // Enable gating
    repeat (3) pulse(1'b1);
    settle();
    chk("pre_disable", cnt_out, 32'h00000003);
    enable = 1'b0;
    repeat (5) pulse(1'($urandom_range(0, 1)));
    settle();
    chk("disabled_cnt", cnt_out, 32'h00000003);
    enable = 1'b1;

    // Clear coincident with an event: the event is dropped
    @(negedge clk);
    up_down   = 1'b1;
    cnt_pulse = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    cnt_pulse = 1'b0;
    idle(2);
    settle();
    chk("clear_collision", cnt_out, 32'h0);

    // Event landing on the tick cycle is published one period later
    wait_pc(13);
    up_down   = 1'b1;
    cnt_pulse = 1'b1;
    idle(3);
    chk("tick_collision_hold", cnt_out, 32'h0);
    cnt_pulse = 1'b0;
    idle(2);
    settle();
    chk("tick_collision_next", cnt_out, 32'h00000001);

    // Random mix of directions, enable, clear and gaps
    repeat (300) begin
      if ($urandom_range(0, 9) == 0) enable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) clear_pulse();
      pulse(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) idle($urandom_range(0, 20));
    end
    enable = 1'b1;
    settle();
    chk("rand_final", cnt_out, to_bcd(live_m));

    // Asynchronous reset mid-run with live = 42 and overflow set
    clear_pulse();
    pulse(1'b0);
    repeat (43) pulse(1'b1);
    settle();
    chk("pre_reset_cnt", cnt_out, 32'h00000042);
    chk("pre_reset_ovf", {31'b0, overflow}, 32'h1);
    wait_pc(7);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_cnt", cnt_out, 32'h0);
    chk("async_rst_trigger", {31'b0, trigger}, 32'h0);
    chk("async_rst_ovf", {31'b0, overflow}, 32'h0);
    idle(2);
    reset = 1'b1;
    first_trigger("post_reset_trigger_cycle");
    idle(2*P);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bcd_event_counter.md
# bcd_event_counter

Eight-digit packed-BCD up/down event counter that feeds the 7-segment decode/shift stage. It synchronizes an asynchronous count input and keeps a live BCD count. At a fixed update rate it publishes a stable snapshot on `cnt_out` with a one-cycle `trigger` pulse, so the downstream shifter is never restarted mid-frame.

## Interface
- `UPDATE_PERIOD`, default 128: clock cycles between update opportunities. Legal range is 2..65535. It must exceed the downstream shift-frame length.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset. Assertion is immediate; deassertion is synchronous to `clk` at system level. One clock; reset is asynchronous and active-low.
- `cnt_pulse`  in  1  asynchronous count event; each rising edge counts once.
- `up_down`  in  1  direction: 1 = increment, 0 = decrement. Sampled in the event cycle.
- `enable`  in  1  synchronous; 0 discards count events.
- `clear`  in  1  synchronous; zeroes the live count and clears `overflow`.
- `cnt_out`  out  32  published snapshot. Packed BCD; digit 0 (least significant) in [3:0], digit 7 in [31:28].
- `trigger`  out  1  one-cycle pulse. Asserted in the same cycle a new `cnt_out` first appears.
- `overflow`  out  1  sticky flag; set on any wrap.

## Operation
- **Input synchronizer and edge detect.**
  - `cnt_pulse` passes through two flip-flops (s1, s2) and then a third register (s3).
  - The event is `s2 & ~s3`.
  - `cnt_pulse` must be high ≥2 cycles and low ≥2 cycles; shorter pulses may be lost.
- **Live counter.** Eight BCD digits, updated on an event cycle when `enable`=1.
  - Up: a digit at 9 goes to 0 and carries into the next digit; otherwise the digit increments.
  - Down: a digit at 0 goes to 9 and borrows from the next digit; otherwise the digit decrements.
  - Wrap: 99999999+1 → 00000000 and 00000000−1 → 99999999. Each wrap sets `overflow`.
  - Nibble values A–F are unreachable. No state may produce them.
- **Clear.**
  - Live count → 0 and `overflow` → 0.
  - Sets the `force` flag.
  - `clear` beats a coincident event; that event is dropped.
  - `cnt_out` is not touched until the next tick.
- **Prescaler.**
  - Counts 0..UPDATE_PERIOD−1 and wraps. `tick` = (prescaler == UPDATE_PERIOD−1).
  - Free-running; it is not affected by `enable` or `clear`.
- **Publish.** On a `tick` cycle, if (live ≠ `cnt_out`) or `force`:
  - `cnt_out` ← live, registered.
  - `trigger` ← 1 for exactly one cycle.
  - `force` ← 0.
  - If neither condition holds, there is no trigger.
- **Simultaneous event and tick.** `tick` samples the live register value before that cycle's increment. The event appears at a later tick.
- **Reset state.**
  - Live count = 0, `cnt_out` = 0, `trigger` = 0, `overflow` = 0.
  - Prescaler = 0, s1/s2/s3 = 0.
  - `force` = 1, so the first tick after reset publishes 00000000 with a trigger.
- **Reset mid-operation.** All of the above take effect immediately. A pending publish is abandoned.

## Timing
- **Count latency.** If `cnt_pulse` is first sampled high at edge k, s2 = 1 after edge k+1 and the live count changes at edge k+2.
- **First trigger.** Asserted after the UPDATE_PERIOD-th rising edge following reset release.
- **Trigger spacing.** Consecutive triggers are ≥ UPDATE_PERIOD cycles apart. A trigger is always exactly one cycle wide.
- **Display latency.** From the `cnt_pulse` rising edge to `cnt_out` updating takes ≤ 3 + UPDATE_PERIOD cycles.
- **Output stability.** `cnt_out` is stable for ≥ UPDATE_PERIOD cycles after each trigger.
- **Glitch-free outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset and first publish.** Bench uses UPDATE_PERIOD=16. Release reset with no pulses → `trigger` high only in cycle 16, `cnt_out`=0x00000000, `overflow`=0. No further triggers while idle.
- **Up count with carry.**
  - Stimulus: 1234 up pulses (each 2 high / 2 low cycles), `enable`=1.
  - Required: `cnt_out`=0x00001234 after the next tick. Nibbles are never >9 at any point.
  - Intermediate checks: count 9 → 0x00000009, count 10 → 0x00000010.
- **Down and underflow wrap.**
  - From 0x00000001, two down pulses → `cnt_out`=0x99999999 and `overflow`=1.
  - `overflow` stays 1 until `clear`; after `clear` it is 0 and the next tick publishes 0x00000000 with a trigger.
- **Up overflow.** Preload via pulses, or use a bench with force-loaded live count 0x99999999. One up pulse → 0x00000000, `overflow`=1.
- **Enable, clear and collision.**
  - `enable`=0 for 5 pulses → count unchanged, no trigger.
  - `clear` asserted in the same cycle as an event → live=0 and that event is not counted.
  - An event landing exactly on a tick cycle is published at the following tick, not the current one.
- **Asynchronous reset mid-run.**
  - Assert `reset`=0 while live=0x00000042 and prescaler mid-count.
  - Required: `cnt_out`=0, `trigger`=0, `overflow`=0 immediately, without waiting for a clock.
  - After release, the first trigger follows exactly 16 cycles later, publishing 0x00000000.
